mult_div_unit: RTL and testbench

Iterative MIPS HI/LO multiply/divide unit in the execute stage, directly downstream of the register file. Consumes the two register-file read operands (rs → `a`, rt → `b`) for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Holds the architectural HI and LO registers and presents them for MFHI/MFLO. A `busy` flag lets the pipeline control stall on HI/LO hazards.

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS HI/LO multiply/divide unit.
// Signed ops work on magnitudes; the sign is restored in the FINISH state.
// Optional build macro MDU_FAST_MULT_EN selects a single-cycle multiplier
// for MULT/MULTU. Divides always use the 32-step restoring divider.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FINISH
   } state_t;

   state_t               state;
   logic [5:0]           count;
   logic [2*WIDTH-1:0]   acc;      // product accumulator, or dividend/quotient in [WIDTH-1:0]
   logic [WIDTH:0]       rem;      // partial remainder
   logic [WIDTH-1:0]     dvsr;     // multiplicand magnitude or divisor magnitude
   logic                 is_div;
   logic                 neg_q;    // negate product / quotient at FINISH
   logic                 neg_r;    // negate remainder at FINISH

   logic                 signed_op;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 sign_diff;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
`ifdef MDU_FAST_MULT_EN
   logic [2*WIDTH-1:0]   fast_prod;
`endif

   // Magnitude of a value, treating it as two's complement only when sgn is set.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic sgn);
      if (sgn && (v < 0))
         return WIDTH'(-v);
      return v;
   endfunction

   // Conditional two's-complement negate, single width (quotient/remainder).
   function automatic logic [WIDTH-1:0] cneg1(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // Conditional two's-complement negate, double width (product).
   function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // Operand conditioning at acceptance plus one shift-add / restoring-divide step.
   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      mag_a     = magnitude(a, signed_op);
      mag_b     = magnitude(b, signed_op);
      sign_diff = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : {(WIDTH+1){1'b0}});
      div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, dvsr});
      div_diff  = div_shift - {1'b0, dvsr};
`ifdef MDU_FAST_MULT_EN
      fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
   end

   // Control FSM, iteration datapath and architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         acc    <= '0;
         rem    <= '0;
         dvsr   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_MULT, OP_MULTU: begin
                        is_div <= 1'b0;
                        neg_q  <= sign_diff;
                        neg_r  <= 1'b0;
                        busy   <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                        acc    <= fast_prod;
                        state  <= S_FINISH;
`else
                        acc    <= {{WIDTH{1'b0}}, mag_b};
                        dvsr   <= mag_a;
                        count  <= '0;
                        state  <= S_RUN;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        is_div <= 1'b1;
                        busy   <= 1'b1;
                        if (b == '0) begin
                           // Divide by zero: preload the fixed result, skip iterations.
                           acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                           rem   <= {1'b0, a};
                           neg_q <= 1'b0;
                           neg_r <= 1'b0;
                           state <= S_FINISH;
                        end else begin
                           acc   <= {{WIDTH{1'b0}}, mag_a};
                           rem   <= '0;
                           dvsr  <= mag_b;
                           neg_q <= sign_diff;
                           neg_r <= signed_op && a[WIDTH-1];
                           count <= '0;
                           state <= S_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               count <= count + 6'd1;
               if (is_div) begin
                  rem             <= div_ge ? div_diff : div_shift;
                  acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
               if (count == LAST_ITER)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               if (is_div) begin
                  lo <= cneg1(acc[WIDTH-1:0], neg_q);
                  hi <= cneg1(rem[WIDTH-1:0], neg_r);
               end else begin
                  {hi, lo} <= cneg2(acc, neg_q);
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and
// latency, a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

`ifdef MDU_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [31:0] ehi;
      logic [31:0] elo;
      int          issue;
      int          lat;
      string       name;
   } exp_t;
   exp_t sbq[$];

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural HI/LO state.
   function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ch, input logic [31:0] cl,
                                 output logic [31:0] rh, output logic [31:0] rl,
                                 output int lat, output bit hd);
      longint      sx, sy, sp, sq, sr;
      logic [63:0] p, q, r, ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      rh = ch; rl = cl; lat = 0; hd = 1'b0;
      case (o)
         3'd0: begin sp = sx * sy; p = sp; rh = p[63:32]; rl = p[31:0]; lat = MUL_LAT; hd = 1'b1; end
         3'd1: begin p = ux * uy; rh = p[63:32]; rl = p[31:0]; lat = MUL_LAT; hd = 1'b1; end
         3'd2, 3'd3: begin
            hd = 1'b1;
            if (y == 32'd0) begin
               rl = 32'hFFFF_FFFF; rh = x; lat = 1;
            end else if (o == 3'd2) begin
               sq = sx / sy; sr = sx % sy; q = sq; r = sr;
               rl = q[31:0]; rh = r[31:0]; lat = 33;
            end else begin
               q = ux / uy; r = ux % uy;
               rl = q[31:0]; rh = r[31:0]; lat = 33;
            end
         end
         3'd4: rh = x;
         3'd5: rl = x;
         default: ;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset && done) begin
         if (sbq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_done: done=1 at cycle %0d with no operation pending", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_hi"}, 64'(hi), 64'(e.ehi));
            chk({e.name, "_lo"}, 64'(lo), 64'(e.elo));
            chk({e.name, "_lat"}, 64'(cyc - e.issue), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
      logic [31:0] eh, el, oh, ol;
      int lat;
      bit hd;
      oh = m_hi; ol = m_lo;
      model(o, x, y, m_hi, m_lo, eh, el, lat, hd);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if (hd) begin
         sbq.push_back('{ehi: eh, elo: el, issue: cyc, lat: lat, name: nm});
         chk({nm, "_busy"}, 64'(busy), 64'd1);
         chk({nm, "_hold_hi"}, 64'(hi), 64'(oh));
         chk({nm, "_hold_lo"}, 64'(lo), 64'(ol));
      end else begin
         chk({nm, "_hi"}, 64'(hi), 64'(eh));
         chk({nm, "_lo"}, 64'(lo), 64'(el));
         chk({nm, "_busy"}, 64'(busy), 64'd0);
      end
      m_hi = eh; m_lo = el;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 100);
      if (busy) begin
         nchk++;
         nerr++;
         $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", nm, busy, n);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y, old_hi;
      logic [2:0]  o;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);

      issue(3'd4, 32'h00FF00FF, 32'h0, "mthi");
      issue(3'd5, 32'hAA55AA55, 32'h0, "mtlo");
      wait_idle("mt");
      chk("mt_pair_hi", 64'(hi), 64'h00FF00FF);

      issue(3'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");        wait_idle("mult_neg");
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max"); wait_idle("multu_max");
      issue(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");          wait_idle("div_neg");
      issue(3'd3, 32'd100, 32'd7, "divu");                  wait_idle("divu");
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_wrap");  wait_idle("div_wrap");
      issue(3'd3, 32'h00001234, 32'd0, "divu_zero");        wait_idle("divu_zero");
      issue(3'd2, 32'h80000001, 32'd0, "div_zero");         wait_idle("div_zero");
      issue(3'd6, 32'h12345678, 32'd1, "nop6");             wait_idle("nop6");
      issue(3'd0, 32'd6, 32'd7, "mult_6x7");                wait_idle("mult_6x7");

      // start during RUN must be ignored
      old_hi = m_hi;
      issue(3'd1, 32'd3, 32'd5, "multu_ign");
`ifdef MDU_FAST_MULT_EN
      wait_idle("multu_ign");
`else
      repeat (9) @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'h0000DEAD;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_busy", 64'(busy), 64'd1);
      chk("ign_hold_hi", 64'(hi), 64'(old_hi));
      wait_idle("multu_ign");
`endif
      chk("ign_final_hi", 64'(hi), 64'd0);

      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) y = {27'b0, 5'($urandom_range(1, 31))};
         issue(o, x, y, $sformatf("rnd%0d_op%0d", i, o));
         wait_idle("rnd");
      end

      // reset in the middle of a divide aborts it
      issue(3'd3, 32'd100, 32'd7, "divu_abort");
      repeat (11) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sbq.delete();
      m_hi = '0; m_lo = '0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);

      issue(3'd0, 32'd6, 32'd7, "post_mult"); wait_idle("post_mult");
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
